csr_seq: RTL and testbench
==========================

Name: csr_seq

Overview:
- Multi-cycle sequencer for RISC-V Zicsr instructions (opcode bits [6:2] = 5'b11100) in the decode/execute boundary.
- Accepts one raw instruction plus rs1 operand and forms the source: rs1_data for register forms, or zero-extended uimm {27'b0, ins[19:15]} for immediate forms.
- Runs read-modify-write against the CSR file over a req/ack handshake, then returns the old value to the register file.
- Stalls the front end while busy.

Parameters:
- XLEN, 32, data width of operands and CSR data.
- TIMEOUT_CYCLES, 16, ack-wait limit; used only when CSR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ins_valid  in  1  instruction offered.
- ins  in  32  raw instruction word.
- rs1_data  in  XLEN  rs1 register value, sampled at accept.
- ins_ready  out  1  sequencer can accept an instruction.
- stall  out  1  front-end stall; high whenever state != IDLE.
- csr_req  out  1  CSR access request.
- csr_we  out  1  1 = write access, 0 = read access.
- csr_addr  out  12  CSR address, ins[31:20] latched at accept.
- csr_wdata  out  XLEN  write data.
- csr_rdata  in  XLEN  read data, valid with csr_ack.
- csr_ack  in  1  access complete; may be asserted in the same cycle as csr_req.
- csr_err  in  1  access fault; qualified by csr_ack.
- rd_we  out  1  register-file write enable, one-cycle pulse.
- rd_addr  out  5  destination register.
- rd_data  out  XLEN  old CSR value.
- fault  out  1  one-cycle pulse on illegal or aborted instruction.

Behaviour:
- Reset, asynchronous: state = IDLE; all latched fields cleared to 0.
  - All outputs 0 except ins_ready = 1.
  - Reset during READ or WRITE drops csr_req immediately. No rd write or fault is issued for the aborted instruction.
- Accept: in IDLE, ins_ready = 1. ins_valid && ins_ready is the accept cycle. Latch these fields:
  - funct3 = ins[14:12]
  - rd = ins[11:7]
  - src_idx = ins[19:15]
  - addr = ins[31:20]
  - src = rs1_data if funct3[2] = 0, else {27'b0, ins[19:15]}
- Illegal at accept: ins[6:2] != 5'b11100, or funct3 in {000, 100}.
  - Instruction is consumed.
  - fault pulses in the next cycle.
  - State stays IDLE.
- Op decode from funct3[1:0]: 01 = RW, 10 = RS, 11 = RC.
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> READ: legal accept, unless op = RW && rd == 0.
  - IDLE -> WRITE: legal accept with op = RW && rd == 0 (read is suppressed, no read side effect).
  - READ: csr_req = 1, csr_we = 0, csr_addr held.
    - On csr_ack && !csr_err: old <= csr_rdata.
    - If (RS or RC) && src_idx == 0, go to RESP (write suppressed).
    - Otherwise go to WRITE.
  - WRITE: csr_req = 1, csr_we = 1, csr_wdata = new.
    - new for RW = src.
    - new for RS = old | src.
    - new for RC = old & ~src.
    - On csr_ack go to RESP.
  - RESP: rd_we = (rd != 0) for exactly one cycle; rd_addr = rd, rd_data = old. Then go to IDLE.
  - Error: csr_ack && csr_err in READ or WRITE → go to IDLE, pulse fault for one cycle, no rd_we.
- Handshake rules:
  - csr_req, csr_we, csr_addr and csr_wdata stay stable until csr_ack.
  - csr_req deasserts in the cycle after ack.
  - csr_ack while csr_req = 0 is ignored.
- Latency, zero-wait ack: RS with write = accept (T0), READ (T1), WRITE (T2), RESP with rd_we (T3).
  - Next accept is possible at T4.
  - Back-to-back instructions are never overlapped.
- stall = (state != IDLE). ins_ready = (state == IDLE).

Optional Feature:
- CSR_TIMEOUT_EN
- Defined:
  - A wait counter resets on entry to READ or WRITE and increments each cycle csr_req is high without csr_ack.
  - When it reaches TIMEOUT_CYCLES: drop csr_req, pulse fault, return to IDLE, no rd_we.
  - A late csr_ack after the timeout is ignored.
- Undefined: no counter; waits indefinitely for csr_ack.

Test Plan:
- CSRRS x5, 0x300, x6 with rs1_data = 0x0000_0008; CSR returns 0x0000_1800 with zero-wait ack:
  - read at T1
  - write csr_wdata = 0x0000_1808 at T2
  - rd_we = 1, rd_addr = 5, rd_data = 0x0000_1800 at T3
  - stall high T1–T3
- CSRRWI x0, 0x340, uimm = 0x1F: no read request; single write with csr_wdata = 0x0000_001F; no rd_we.
- CSRRC x7, 0x300, x0: read only, no write access, rd_data = old value to x7. Same for CSRRSI with uimm = 0.
- Write acked with csr_err = 1 after 3 wait cycles: request held stable for 3 cycles, fault pulse, no rd_we, ins_ready = 1 next cycle.
- ins = 0x0000_0073 (ECALL, funct3 000) and an ADDI: each consumed in one cycle, fault pulse, no csr_req.
- rst_n low while in WRITE waiting for ack: csr_req = 0 immediately, all outputs at reset values. With CSR_TIMEOUT_EN defined, no ack for 16 cycles → fault pulse and IDLE.

Source files
------------

// File: rtl/csr_seq.sv
// csr_seq: multi-cycle sequencer for RISC-V Zicsr instructions.
// Accepts one raw instruction with its rs1 operand, runs a read-modify-write
// against the CSR file over a req/ack handshake and returns the old CSR value
// to the register file. The front end is stalled while a sequence is running.
//
// Optional feature: define CSR_TIMEOUT_EN to abort an access that is not
// acknowledged within TIMEOUT_CYCLES cycles (fault pulse, back to IDLE).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ins_valid, ins        instruction offer and raw 32-bit instruction word
//   rs1_data              rs1 register value, sampled at accept
//   ins_ready             sequencer idle and able to accept
//   stall                 front-end stall, high whenever not idle
//   csr_req/we/addr/wdata CSR access request, held stable until csr_ack
//   csr_rdata/ack/err     CSR response; csr_err is qualified by csr_ack
//   rd_we/addr/data       one-cycle register-file write of the old CSR value
//   fault                 one-cycle pulse on illegal or aborted instruction
module csr_seq #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ins_valid,
  input  logic [31:0]     ins,
  input  logic [XLEN-1:0] rs1_data,
  output logic            ins_ready,
  output logic            stall,
  output logic            csr_req,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_ack,
  input  logic            csr_err,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            fault
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 2;

  localparam logic [4:0]      OPC_SYSTEM = 5'b11100;
  localparam logic [OP_W-1:0] OP_RW      = 2'b01;
  localparam logic [OP_W-1:0] OP_RS      = 2'b10;
  localparam logic [OP_W-1:0] OP_RC      = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // New CSR value for the write phase
  function automatic logic [XLEN-1:0] rmw(input logic [OP_W-1:0] op,
                                          input logic [XLEN-1:0] old,
                                          input logic [XLEN-1:0] src);
    case (op)
      OP_RS:   rmw = old | src;
      OP_RC:   rmw = old & ~src;
      default: rmw = src;
    endcase
  endfunction

  state_e            state_q,     state_d;
  logic [OP_W-1:0]   op_q,        op_d;
  logic [REG_W-1:0]  rd_q,        rd_d;
  logic [REG_W-1:0]  src_idx_q,   src_idx_d;
  logic [XLEN-1:0]   src_q,       src_d;
  logic [XLEN-1:0]   old_q,       old_d;
  logic              ins_ready_q, ins_ready_d;
  logic              stall_q,     stall_d;
  logic              csr_req_q,   csr_req_d;
  logic              csr_we_q,    csr_we_d;
  logic [ADDR_W-1:0] csr_addr_q,  csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              rd_we_q,     rd_we_d;
  logic [REG_W-1:0]  rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0]   rd_data_q,   rd_data_d;
  logic              fault_q,     fault_d;

`ifdef CSR_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Accept-time decode straight from the instruction word
  logic [OP_W-1:0]  ins_op;
  logic [REG_W-1:0] ins_rd;
  logic             ins_illegal;
  logic             unused_ins_lsb;

  assign ins_op         = ins[13:12];
  assign ins_rd         = ins[11:7];
  assign ins_illegal    = (ins[6:2] != OPC_SYSTEM) || (ins_op == 2'b00);
  assign unused_ins_lsb = ^ins[1:0];

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    src_idx_d   = src_idx_q;
    src_d       = src_q;
    old_d       = old_q;
    csr_req_d   = csr_req_q;
    csr_we_d    = csr_we_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    rd_we_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    fault_d     = 1'b0;
`ifdef CSR_TIMEOUT_EN
    wait_d      = wait_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          op_d       = ins_op;
          rd_d       = ins_rd;
          src_idx_d  = ins[19:15];
          csr_addr_d = ins[31:20];
          src_d      = ins[14] ? XLEN'(ins[19:15]) : rs1_data;
          if (ins_illegal) begin
            fault_d = 1'b1;
          end else begin
            csr_req_d = 1'b1;
`ifdef CSR_TIMEOUT_EN
            wait_d    = '0;
`endif
            // CSRRW(I) to x0 must not read the CSR: go straight to the write
            if (ins_op == OP_RW && ins_rd == '0) begin
              state_d     = S_WRITE;
              csr_we_d    = 1'b1;
              csr_wdata_d = src_d;
            end else begin
              state_d  = S_READ;
              csr_we_d = 1'b0;
            end
          end
        end
      end

      S_READ: begin
        if (csr_ack) begin
          if (csr_err) begin
            state_d   = S_IDLE;
            csr_req_d = 1'b0;
            fault_d   = 1'b1;
          end else begin
            old_d = csr_rdata;
            // Set/clear with a zero source has no write side effect
            if (op_q != OP_RW && src_idx_q == '0) begin
              state_d   = S_RESP;
              csr_req_d = 1'b0;
              rd_we_d   = (rd_q != '0);
              rd_addr_d = rd_q;
              rd_data_d = csr_rdata;
            end else begin
              state_d     = S_WRITE;
              csr_we_d    = 1'b1;
              csr_wdata_d = rmw(op_q, csr_rdata, src_q);
`ifdef CSR_TIMEOUT_EN
              wait_d      = '0;
`endif
            end
          end
        end
      end

      S_WRITE: begin
        if (csr_ack) begin
          csr_req_d = 1'b0;
          csr_we_d  = 1'b0;
          if (csr_err) begin
            state_d = S_IDLE;
            fault_d = 1'b1;
          end else begin
            state_d   = S_RESP;
            rd_we_d   = (rd_q != '0);
            rd_addr_d = rd_q;
            rd_data_d = old_q;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        csr_req_d = 1'b0;
        csr_we_d  = 1'b0;
      end
    endcase

`ifdef CSR_TIMEOUT_EN
    // Abort an access that waits too long; a late ack then lands in IDLE
    if ((state_q == S_READ || state_q == S_WRITE) && !csr_ack) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_IDLE;
        csr_req_d = 1'b0;
        csr_we_d  = 1'b0;
        fault_d   = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
`endif

    ins_ready_d = (state_d == S_IDLE);
    stall_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      src_idx_q   <= '0;
      src_q       <= '0;
      old_q       <= '0;
      ins_ready_q <= 1'b1;
      stall_q     <= 1'b0;
      csr_req_q   <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      fault_q     <= 1'b0;
`ifdef CSR_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      src_idx_q   <= src_idx_d;
      src_q       <= src_d;
      old_q       <= old_d;
      ins_ready_q <= ins_ready_d;
      stall_q     <= stall_d;
      csr_req_q   <= csr_req_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      fault_q     <= fault_d;
`ifdef CSR_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign ins_ready = ins_ready_q;
  assign stall     = stall_q;
  assign csr_req   = csr_req_q;
  assign csr_we    = csr_we_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign rd_we     = rd_we_q;
  assign rd_addr   = rd_addr_q;
  assign rd_data   = rd_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_csr_seq.sv
// Directed bench for csr_seq with an event scoreboard: expected CSR accesses,
// register writes and fault pulses are queued when an instruction is issued
// and popped in order as the DUT produces them.
module tb_csr_seq;

  localparam int unsigned XLEN = 32;
  localparam logic [7:0] K_ACC = 8'd1;
  localparam logic [7:0] K_RD  = 8'd2;
  localparam logic [7:0] K_FLT = 8'd3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ins_valid;
  logic [31:0]     ins;
  logic [XLEN-1:0] rs1_data;
  logic            ins_ready;
  logic            stall;
  logic            csr_req;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_ack;
  logic            csr_err;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            fault;

  // CSR responder knobs
  int              rsp_wait = 0;
  logic            rsp_err  = 1'b0;
  logic            rsp_hold = 1'b0;
  logic [XLEN-1:0] rsp_rdata = '0;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  csr_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_valid (ins_valid),
    .ins       (ins),
    .rs1_data  (rs1_data),
    .ins_ready (ins_ready),
    .stall     (stall),
    .csr_req   (csr_req),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_ack   (csr_ack),
    .csr_err   (csr_err),
    .rd_we     (rd_we),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .fault     (fault)
  );

  function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {csr, rs1, f3, rd, 7'b1110011};
  endfunction

  function automatic logic [63:0] ev(input logic [7:0] kind, input logic we,
                                     input logic [11:0] a, input logic [31:0] d);
    return {kind, 7'b0, we, 4'b0, a, d};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [63:0] obs);
    n_asserts++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s unexpected event observed=%0h expected=none", tag, obs);
    end
    if (exp_q.size() != 0) check(tag, 128'(obs), 128'(exp_q.pop_front()));
  endtask

  task automatic check_reset(input string tag);
    check(tag, 128'({ins_ready, stall, csr_req, csr_we, csr_addr, csr_wdata,
                     rd_we, rd_addr, rd_data, fault}),
               128'({1'b1, 86'b0}));
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] r1);
    @(posedge clk); #1;
    ins_valid = 1'b1; ins = w; rs1_data = r1;
    @(posedge clk); #1;
    ins_valid = 1'b0; ins = '0; rs1_data = '0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ins_ready && k < 64);
    check(tag, 128'(ins_ready), 128'(1'b1));
  endtask

  // CSR file responder: ack after rsp_wait wait cycles unless held off
  initial begin
    int wcnt;
    wcnt = 0;
    csr_ack = 1'b0; csr_err = 1'b0; csr_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (csr_req && !rsp_hold && wcnt >= rsp_wait) begin
        csr_ack = 1'b1; csr_err = rsp_err; csr_rdata = rsp_rdata; wcnt = 0;
      end else begin
        csr_ack = 1'b0; csr_err = 1'b0; csr_rdata = '0;
        if (csr_req) wcnt++;
        else wcnt = 0;
      end
    end
  end

  // Monitor: scoreboard events and request stability while waiting for ack
  initial begin
    logic p_req, p_ack, p_we;
    logic [11:0] p_addr;
    logic [31:0] p_wdata;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (csr_req && csr_ack)
          sb_pop("csr_access", ev(K_ACC, csr_we, csr_addr, csr_we ? csr_wdata : 32'h0));
        if (rd_we) sb_pop("rd_write", ev(K_RD, 1'b0, 12'(rd_addr), rd_data));
        if (fault) sb_pop("fault", ev(K_FLT, 1'b0, 12'h0, 32'h0));
        if (p_req && !p_ack && csr_req)
          check("req_stable", 128'({csr_we, csr_addr, csr_wdata}),
                              128'({p_we, p_addr, p_wdata}));
        p_req = csr_req; p_ack = csr_ack; p_we = csr_we;
        p_addr = csr_addr; p_wdata = csr_wdata;
      end else begin
        p_req = 1'b0;
      end
    end
  end

  initial begin
    int reqc;
    ins_valid = 1'b0; ins = '0; rs1_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_outputs");
    @(posedge clk); #1 rst_n = 1'b1;

    // CSRRS x5, 0x300, x6: zero-wait, cycle-exact timing
    rsp_wait = 0; rsp_rdata = 32'h0000_1800;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h300, 32'h0));
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h300, 32'h0000_1808));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd5, 32'h0000_1800));
    issue(enc(12'h300, 5'd6, 3'b010, 5'd5), 32'h0000_0008);
    @(negedge clk);
    check("rs_t1_read", 128'({stall, ins_ready, csr_req, csr_we}), 128'(4'b1010));
    @(negedge clk);
    check("rs_t2_write", 128'({stall, csr_req, csr_we, csr_wdata}),
                         128'({3'b111, 32'h0000_1808}));
    @(negedge clk);
    check("rs_t3_resp", 128'({stall, rd_we, csr_req, rd_addr, rd_data}),
                        128'({3'b110, 5'd5, 32'h0000_1800}));
    @(negedge clk);
    check("rs_t4_idle", 128'({stall, ins_ready}), 128'(2'b01));

    // CSRRWI x0, 0x340, 0x1F: write only, no rd write
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h340, 32'h0000_001F));
    issue(enc(12'h340, 5'h1F, 3'b101, 5'd0), 32'hFFFF_FFFF);
    @(negedge clk);
    check("rwi_direct_write", 128'({csr_req, csr_we, csr_addr, csr_wdata}),
                              128'({2'b11, 12'h340, 32'h0000_001F}));
    wait_idle("rwi_idle");

    // CSRRC x7, 0x300, x0: read only
    rsp_rdata = 32'h0000_1808;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h300, 32'h0));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd7, 32'h0000_1808));
    issue(enc(12'h300, 5'd0, 3'b011, 5'd7), 32'hFFFF_FFFF);
    wait_idle("rc_x0_idle");

    // CSRRSI x8, 0x305, 0: read only
    rsp_rdata = 32'hA5A5_0000;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h305, 32'h0));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd8, 32'hA5A5_0000));
    issue(enc(12'h305, 5'd0, 3'b110, 5'd8), 32'h0);
    wait_idle("rsi_zero_idle");

    // CSRRC x9, 0x300, x10: clear bits
    rsp_rdata = 32'h0000_1808;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h300, 32'h0));
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h300, 32'h0000_1008));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd9, 32'h0000_1808));
    issue(enc(12'h300, 5'd10, 3'b011, 5'd9), 32'h0000_0800);
    wait_idle("rc_idle");

    // CSRRW x11, 0x7C0, x12 with two wait cycles per access
    rsp_wait = 2; rsp_rdata = 32'h1234_5678;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h7C0, 32'h0));
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h7C0, 32'hDEAD_BEEF));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd11, 32'h1234_5678));
    issue(enc(12'h7C0, 5'd12, 3'b001, 5'd11), 32'hDEAD_BEEF);
    wait_idle("rw_wait_idle");

    // CSRRS x0, 0x300, x6: read and write happen, rd write suppressed
    rsp_wait = 0; rsp_rdata = 32'h0000_0010;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h300, 32'h0));
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h300, 32'h0000_0011));
    issue(enc(12'h300, 5'd6, 3'b010, 5'd0), 32'h0000_0001);
    wait_idle("rs_x0_idle");

    // Write acked with error after 3 wait cycles
    rsp_wait = 3; rsp_err = 1'b1;
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h341, 32'h0000_0005));
    exp_q.push_back(ev(K_FLT, 1'b0, 12'h0, 32'h0));
    issue(enc(12'h341, 5'd5, 3'b101, 5'd0), 32'h0);
    reqc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (csr_req) reqc++;
      if (fault) break;
    end
    check("err_req_cycles", 128'(reqc), 128'(4));
    check("err_fault_cycle", 128'({fault, ins_ready, rd_we, csr_req}), 128'(4'b1100));
    rsp_wait = 0; rsp_err = 1'b0;

    // Illegal instructions: ECALL, ADDI, SYSTEM with funct3 100
    begin
      logic [31:0] bad [3];
      bad[0] = 32'h0000_0073;
      bad[1] = 32'h0010_0093;
      bad[2] = enc(12'h300, 5'd1, 3'b100, 5'd1);
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(ev(K_FLT, 1'b0, 12'h0, 32'h0));
        issue(bad[i], 32'h0);
        @(negedge clk);
        check($sformatf("illegal_%0d", i), 128'({fault, ins_ready, csr_req, stall}),
                                           128'(4'b1100));
      end
    end

    // Reset while a write waits for ack
    rsp_hold = 1'b1;
    issue(enc(12'h342, 5'd3, 3'b101, 5'd0), 32'h0);
    repeat (3) @(negedge clk);
    check("write_pending", 128'({csr_req, csr_we, stall}), 128'(3'b111));
    #1 rst_n = 1'b0;
    #1 check_reset("reset_in_write");
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_hold = 1'b0;

    // Recovery after reset
    rsp_rdata = 32'h0000_00F0;
    exp_q.push_back(ev(K_ACC, 1'b0, 12'h300, 32'h0));
    exp_q.push_back(ev(K_ACC, 1'b1, 12'h300, 32'h0000_00FF));
    exp_q.push_back(ev(K_RD, 1'b0, 12'd5, 32'h0000_00F0));
    issue(enc(12'h300, 5'd6, 3'b010, 5'd5), 32'h0000_000F);
    wait_idle("recover_idle");

`ifdef CSR_TIMEOUT_EN
    // No ack at all: abort after 16 request cycles
    rsp_hold = 1'b1;
    exp_q.push_back(ev(K_FLT, 1'b0, 12'h0, 32'h0));
    issue(enc(12'h300, 5'd6, 3'b010, 5'd5), 32'h0000_0008);
    reqc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (csr_req) reqc++;
      if (fault) break;
    end
    check("timeout_req_cycles", 128'(reqc), 128'(16));
    check("timeout_fault_cycle", 128'({fault, ins_ready, csr_req, rd_we}), 128'(4'b1100));
    rsp_hold = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
